// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin
// arbiter that drives the 4:1 single-bit mux select pair.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(
    input logic [N_REQ-1:0] oh
  );
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(
    input logic [SEL_W-1:0] idx
  );
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: scans req starting at
// index start (wrapping), skipping exclude_mask bits.
// Ports: req, start, exclude_mask in; valid, idx out.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  input  logic [N_REQ-1:0] exclude_mask,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] elig;
  logic [SEL_W-1:0] cand;

  assign elig = req & ~exclude_mask;

  // Scan from the farthest offset back to offset 0 so the
  // nearest eligible requester to start is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (elig[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 mux.
// Registers a one-hot grant and the mux select pair.
// Ports: clk, rst (async high); req[3:0] in;
//   grant[3:0], sel_a (MSB), sel_b (LSB), busy out.
// Optional: ARB_HOLD_LIMIT_EN forces rotation after MAX_HOLD
//   consecutive grant cycles when another requester waits.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             sel_a,
  output logic             sel_b,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] pick_start;
  logic [N_REQ-1:0] pick_excl;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_hit;
  logic             take;

  assign owner = onehot_to_idx(grant_q);

  // From idle the search begins after the last winner; while
  // granted it begins after the owner, and the owner itself is
  // never a candidate for its own replacement.
  always_comb begin
    pick_start = last_q + SEL_W'(1);
    pick_excl  = '0;
    if (state_q == GRANT) begin
      pick_start = owner + SEL_W'(1);
      pick_excl  = idx_to_onehot(owner);
    end
  end

  rr_pick u_pick (
    .req          (req),
    .start        (pick_start),
    .exclude_mask (pick_excl),
    .valid        (pick_valid),
    .idx          (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    busy_d  = busy_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_valid) take = 1'b1;
      end
      GRANT: begin
        if (!req[owner]) begin
          if (pick_valid) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_hit && pick_valid) begin
          take = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
    if (take) begin
      state_d = GRANT;
      grant_d = idx_to_onehot(pick_idx);
      sel_d   = pick_idx;
      last_d  = pick_idx;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  assign hold_hit = (hold_q == HOLD_TOP);

  // Clears on every new grant, counts grant cycles, and parks at
  // the limit while no one else is waiting.
  always_comb begin
    hold_d = hold_q;
    if (take || state_d == IDLE) begin
      hold_d = '0;
    end else if (state_q == GRANT && !hold_hit) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  logic [7:0] unused_max_hold;

  assign unused_max_hold = 8'(MAX_HOLD);
  assign hold_hit        = 1'b0;
`endif

  assign grant = grant_q;
  assign sel_a = sel_q[1];
  assign sel_b = sel_q[0];
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: expected grant/select
// state is queued with each stimulus step and checked after the edge.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       sel_a;
  logic       sel_b;
  logic       busy;
  logic [3:0] mux_in = 4'b1011;
  logic       mux_out;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t sbq[$];
  logic mbq[$];
  exp_t e;
  logic em;
  int total = 0;
  int bad = 0;

  mux_rr_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .sel_a (sel_a),
    .sel_b (sel_b),
    .busy  (busy)
  );

  assign mux_out = mux_in[{sel_a, sel_b}];

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [3:0] g, input logic [1:0] s, input logic b
  );
    exp_t r;
    r.g = g; r.s = s; r.b = b;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    #3;
    sbq.push_back(mk(4'b0000, 2'b00, 1'b0));
    e = sbq.pop_front();
    total++;
    if ({grant, sel_a, sel_b, busy} !== e) begin
      bad++;
      $display("FAIL reset got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
               grant, sel_a, sel_b, busy, e.g, e.s, e.b);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_rotation;
    logic [3:0] rq[5];
    exp_t ex[5];
    rq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    ex = '{mk(4'b0001, 2'b00, 1'b1), mk(4'b0010, 2'b01, 1'b1),
           mk(4'b0100, 2'b10, 1'b1), mk(4'b1000, 2'b11, 1'b1),
           mk(4'b0000, 2'b11, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      req = rq[i];
      sbq.push_back(ex[i]);
      tick();
      e = sbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL rotation[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 i, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
    end
  endtask

  task automatic test_single;
    logic [3:0] rq[5];
    exp_t ex[5];
    rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ex = '{mk(4'b0100, 2'b10, 1'b1), mk(4'b0100, 2'b10, 1'b1),
           mk(4'b0100, 2'b10, 1'b1), mk(4'b0000, 2'b10, 1'b0),
           mk(4'b0000, 2'b10, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      req = rq[i];
      sbq.push_back(ex[i]);
      tick();
      e = sbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL single[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 i, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] rq[6];
    exp_t ex[6];
    rq = '{4'b1000, 4'b1111, 4'b1111, 4'b1111, 4'b0111, 4'b0000};
    ex = '{mk(4'b1000, 2'b11, 1'b1), mk(4'b1000, 2'b11, 1'b1),
           mk(4'b1000, 2'b11, 1'b1), mk(4'b1000, 2'b11, 1'b1),
           mk(4'b0001, 2'b00, 1'b1), mk(4'b0000, 2'b00, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      req = rq[i];
      sbq.push_back(ex[i]);
      tick();
      e = sbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL wrap[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 i, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] rq[5];
    exp_t ex[5];
    rq = '{4'b0001, 4'b0100, 4'b0101, 4'b0001, 4'b0000};
    ex = '{mk(4'b0001, 2'b00, 1'b1), mk(4'b0100, 2'b10, 1'b1),
           mk(4'b0100, 2'b10, 1'b1), mk(4'b0001, 2'b00, 1'b1),
           mk(4'b0000, 2'b00, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      req = rq[i];
      sbq.push_back(ex[i]);
      tick();
      e = sbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL b2b[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 i, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
    end
  endtask

  task automatic test_mux;
    logic [3:0] rq[4];
    rq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = rq[i];
      sbq.push_back(mk(4'(1) << i, 2'(i), 1'b1));
      mbq.push_back(mux_in[i]);
      tick();
      e = sbq.pop_front();
      em = mbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL mux_grant[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 i, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
      total++;
      if (mux_out !== em) begin
        bad++;
        $display("FAIL mux_out[%0d] got %b want %b", i, mux_out, em);
      end
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    req = 4'b0010;
    #2;
    sbq.push_back(mk(4'b0000, 2'b00, 1'b0));
    e = sbq.pop_front();
    total++;
    if ({grant, sel_a, sel_b, busy} !== e) begin
      bad++;
      $display("FAIL reset_mid got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
               grant, sel_a, sel_b, busy, e.g, e.s, e.b);
    end
    rst = 1'b0;
    sbq.push_back(mk(4'b0010, 2'b01, 1'b1));
    tick();
    e = sbq.pop_front();
    total++;
    if ({grant, sel_a, sel_b, busy} !== e) begin
      bad++;
      $display("FAIL after_reset got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
               grant, sel_a, sel_b, busy, e.g, e.s, e.b);
    end
  endtask

  task automatic test_hold;
    logic [3:0] g;
    req = 4'b0000;
    sbq.push_back(mk(4'b0000, 2'b01, 1'b0));
    tick();
    e = sbq.pop_front();
    total++;
    if ({grant, sel_a, sel_b, busy} !== e) begin
      bad++;
      $display("FAIL hold_idle got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
               grant, sel_a, sel_b, busy, e.g, e.s, e.b);
    end
    req = 4'b0011;
    for (int k = 0; k < 20; k++) begin
`ifdef ARB_HOLD_LIMIT_EN
      g = ((k / 8) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      g = 4'b0001;
`endif
      sbq.push_back(mk(g, (g == 4'b0001) ? 2'b00 : 2'b01, 1'b1));
      tick();
      e = sbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL hold_pair[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 k, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
    end
    req = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      sbq.push_back(mk(4'b0010, 2'b01, 1'b1));
      tick();
      e = sbq.pop_front();
      total++;
      if ({grant, sel_a, sel_b, busy} !== e) begin
        bad++;
        $display("FAIL hold_solo[%0d] got g=%b s=%b%b b=%b want g=%b s=%b b=%b",
                 k, grant, sel_a, sel_b, busy, e.g, e.s, e.b);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_wrap();
    test_back_to_back();
    test_mux();
    test_reset_mid();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing the team's 4:1 single-bit multiplexer among four requesters.
- Registers a one-hot grant and drives the mux select pair sel_a (MSB) / sel_b (LSB), so that the mux output carries the granted requester's input bit.
- Sits between the requesting agents and the combinational multiplexer. Requester i maps to mux input in[i].

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 to match the 2-bit select pair.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation; used only with ARB_HOLD_LIMIT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; level-sensitive; held high for the whole transaction.
- grant  output  4  registered one-hot grant; all zero when idle.
- sel_a  output  1  registered mux select MSB (owner index bit 1).
- sel_b  output  1  registered mux select LSB (owner index bit 0).
- busy  output  1  registered; high while any grant is asserted.

Behaviour:
- Reset: one clock and one reset; reset is asynchronous and active-high, port names clk and rst.
  - Asserting rst immediately forces grant=0, sel_a=0, sel_b=0, busy=0, state IDLE, last pointer=3 (requester 0 wins first), hold counter=0.
  - Reset mid-grant drops the grant the same instant, with no handshake.
- States: IDLE, GRANT.
- Selection function: rotating priority search starting at last+1 mod 4, wrapping. The first set req bit wins.
- IDLE:
  - If req != 0 at a rising edge: grant the selected requester on that edge, set {sel_a,sel_b} to its index, busy=1, last=winner, go to GRANT.
  - Latency is 1 cycle from req sampled high to grant high.
  - If req == 0: stay in IDLE; sel_a/sel_b hold their previous values; grant=0.
- GRANT, owner o:
  - req[o]=1: keep grant and select unchanged.
  - req[o]=0 sampled at an edge:
    - If any other req is set, grant moves directly to the next requester by rotation from o on that same edge (zero bubble cycles). Update sel, set last=new owner.
    - If no other req is set, grant=0, busy=0, go to IDLE, sel held.
  - The released requester is excluded from the same-edge search, even if its req re-rises in the next cycle.
- Non-owner req changes while in GRANT have no effect until rotation.
- Grant is always one-hot or zero. sel_a/sel_b always equal the index of the set grant bit whenever busy=1.
- Simultaneous requests from idle: the winner is by rotation from last. After reset, the order is 0,1,2,3.

Optional Feature:
- Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and another req is set, the grant is forcibly rotated on the next edge even though req[o] is still high.
  - If no other req is set, the owner keeps the grant and the counter saturates.
- Undefined: no counter. The owner keeps the grant indefinitely while req[o]=1.

Decomposition:
- Package mux_arb_pkg:
  - Constants N_REQ=4 and SEL_W=2.
  - State typedef {IDLE, GRANT}.
  - Function onehot_to_idx.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req[3:0], start[1:0], exclude_mask[3:0].
  - Outputs: valid, idx[1:0].
- The top level holds the FSM, registers and hold counter.

Test Plan:
- Reset release with req=4'b1111 -> grant=0001, sel_a/sel_b=00 one cycle later. Drop req[0] -> grant=0010, sel=01 on the next edge, no bubble.
- Single req=4'b0100 from idle -> grant=0100, sel=10, busy=1 after 1 cycle. Release -> grant=0000, busy=0, sel stays 10.
- Requester 3 holds grant while req=4'b1111. Owner drops -> grant=0001 (wrap to 0), sel=00.
- Assert rst mid-grant (grant=1000) -> grant=0, sel=00, busy=0 immediately without a clock. After release, req=0010 -> grant=0010.
- ARB_HOLD_LIMIT_EN with MAX_HOLD=8: req=4'b0011 held constantly -> grant alternates 0001/0010 every 8 cycles. With only req[1] set, grant=0010 persists beyond 8 cycles.
- Connect the mux with in=4'b1011 and all req high -> mux out follows in[owner] sequence 1,1,0,1 as grant rotates.
